// File: rtl/neuron_pkg.sv
// Shared types and Q4.4 constants for the serial MAC neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    FIN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;

  localparam logic [DATA_W-1:0] Z_MAX = 8'h7F;
  localparam logic [DATA_W-1:0] Z_MIN = 8'h80;

  // Smallest accumulator that can hold n full-precision products plus the sign.
  function automatic int min_acc_w(input int n_inputs, input int data_w);
    return 2 * data_w + $clog2(n_inputs) + 1;
  endfunction

endpackage

// File: rtl/neuron_round_sat.sv
// Round-half-up, drop the extra fraction bits and clamp the accumulator to a
// DATA_W-bit Q-format value; sat reports that the clamp was applied.
module neuron_round_sat #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 20
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] z,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    rounded = acc + HALF;
    shifted = rounded >>> FRAC_W;
    z       = shifted[DATA_W-1:0];
    sat     = 1'b0;
    if (shifted > R_MAX) begin
      z   = R_MAX[DATA_W-1:0];
      sat = 1'b1;
    end else if (shifted < R_MIN) begin
      z   = R_MIN[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_serial.sv
// Serial multiply-accumulate neuron: one (x, w) pair per accepted cycle, then
// round/saturate and hold z_value under valid/ready. Option: NEURON_MAC_SAT_FLAG_EN.
module neuron_mac_serial #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = neuron_pkg::DATA_W,
  parameter int FRAC_W   = neuron_pkg::FRAC_W,
  parameter int ACC_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] z_value
`ifdef NEURON_MAC_SAT_FLAG_EN
  ,
  output logic              sat_flag
`endif
);

  import neuron_pkg::*;

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  if (ACC_W < min_acc_w(N_INPUTS, DATA_W)) begin : g_bad_acc_w
    $error("neuron_mac_serial: ACC_W too small for N_INPUTS/DATA_W");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]       z_q, z_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext;
  logic [DATA_W-1:0]          z_rs;

  assign x_ext    = {{DATA_W{x_data[DATA_W-1]}}, x_data};
  assign w_ext    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias is aligned to the Q8.8 product scale before it seeds the accumulator.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

`ifdef NEURON_MAC_SAT_FLAG_EN
  logic sat_rs, sat_q, sat_d;

  neuron_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_round_sat (
    .acc (acc_q),
    .z   (z_rs),
    .sat (sat_rs)
  );
  assign sat_flag = sat_q;
`else
  neuron_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_round_sat (
    .acc (acc_q),
    .z   (z_rs),
    .sat ()
  );
`endif

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign z_value   = z_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
`ifdef NEURON_MAC_SAT_FLAG_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (count_q == '0) acc_d = prod_ext + bias_ext;
          else               acc_d = acc_q + prod_ext;
          if (count_q == LAST) begin
            count_d = '0;
            state_d = FIN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      FIN: begin
        z_d         = z_rs;
        out_valid_d = 1'b1;
        state_d     = HOLD;
`ifdef NEURON_MAC_SAT_FLAG_EN
        sat_d       = sat_rs;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      count_q     <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef NEURON_MAC_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
`ifdef NEURON_MAC_SAT_FLAG_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Directed scoreboard bench for neuron_mac_serial (N_INPUTS=4, Q4.4).
module tb_neuron_mac_serial;
  import neuron_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] bias, x_data, w_data;
  logic       in_ready, out_valid;
  logic [7:0] z_value;
`ifdef NEURON_MAC_SAT_FLAG_EN
  logic       sat_flag;
`endif

  typedef struct packed {
    logic [7:0] z;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  neuron_mac_serial #(.N_INPUTS(N), .DATA_W(8), .FRAC_W(4), .ACC_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_data    (x_data),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_value   (z_value)
`ifdef NEURON_MAC_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of Q8.8 products plus Q4.4 bias, round half up, clamp.
  function automatic exp_t model(input logic [7:0] b, input logic [N-1:0][7:0] xs,
                                 input logic [N-1:0][7:0] ws);
    int   acc;
    int   r;
    exp_t e;
    acc = int'($signed(b)) * 16;
    for (int i = 0; i < N; i++) acc += int'($signed(xs[i])) * int'($signed(ws[i]));
    r = (acc + 8) >>> 4;
    if (r > 127)       e = '{z: 8'h7F, sat: 1'b1};
    else if (r < -128) e = '{z: 8'h80, sat: 1'b1};
    else               e = '{z: r[7:0], sat: 1'b0};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_pair(input logic [7:0] x, input logic [7:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    x_data   = x;
    w_data   = w;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_eval(input logic [7:0] b, input logic [N-1:0][7:0] xs,
                            input logic [N-1:0][7:0] ws, input exp_t e,
                            input int gap, input int hold_cyc);
    exp_t got;
    sb.push_back(e);
    bias = b;
    for (int i = 0; i < N; i++) begin
      send_pair(xs[i], ws[i]);
      if (i == 0) bias = 8'hA5;
      if (i < N - 1) repeat (gap) @(negedge clk);
    end
    check("lat_fin_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_hold_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < hold_cyc; k++) begin
      in_valid = 1'b1;
      x_data   = 8'h33;
      w_data   = 8'h33;
      check("hold_z_stable", {24'd0, z_value}, {24'd0, e.z});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    check("z_value", {24'd0, z_value}, {24'd0, got.z});
`ifdef NEURON_MAC_SAT_FLAG_EN
    check("sat_flag", {31'd0, sat_flag}, {31'd0, got.sat});
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][7:0] xs, ws;
    logic [7:0]        b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    bias = 8'h00; x_data = 8'h00; w_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_z", {24'd0, z_value}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Identity: 4 x (1.0 * 1.0) = 4.0
    drive_eval(8'h00, 32'h10101010, 32'h10101010, '{z: 8'h40, sat: 1'b0}, 0, 0);
    // Bias and sign: 4 x (1.0 * -1.0) + 1.5 = -2.5
    drive_eval(8'h18, 32'h10101010, 32'hF0F0F0F0, '{z: 8'hD8, sat: 1'b0}, 0, 0);
    // Saturation high and low
    drive_eval(8'h00, 32'h7F7F7F7F, 32'h7F7F7F7F, '{z: Z_MAX, sat: 1'b1}, 0, 0);
    drive_eval(8'h00, 32'h80808080, 32'h7F7F7F7F, '{z: Z_MIN, sat: 1'b1}, 0, 0);
    // Rounding boundaries: acc = 8, 7, -8, -9 (Q8.8)
    drive_eval(8'h00, 32'h00000001, 32'h00000008, '{z: 8'h01, sat: 1'b0}, 0, 0);
    drive_eval(8'h00, 32'h00000001, 32'h00000007, '{z: 8'h00, sat: 1'b0}, 0, 0);
    drive_eval(8'h00, 32'h00000001, 32'h000000F8, '{z: 8'h00, sat: 1'b0}, 0, 0);
    drive_eval(8'h00, 32'h00000001, 32'h000000F7, '{z: 8'hFF, sat: 1'b0}, 0, 0);

    // Backpressure with pairs offered during HOLD, then a fresh evaluation
    xs = 32'h20F01008; ws = 32'h11E0300C;
    drive_eval(8'h04, xs, ws, model(8'h04, xs, ws), 1, 5);
    drive_eval(8'h00, 32'h10101010, 32'h10101010, '{z: 8'h40, sat: 1'b0}, 0, 0);

    // Reset after two accepts; no residue afterwards
    send_pair(8'h7F, 8'h7F);
    send_pair(8'h7F, 8'h7F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    drive_eval(8'h00, 32'h10101010, 32'h10101010, '{z: 8'h40, sat: 1'b0}, 0, 0);

    // Reset while holding a result
    bias = 8'h00;
    for (int i = 0; i < N; i++) send_pair(8'h10, 8'h20);
    @(negedge clk);
    check("hold_before_rst", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("holdrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("holdrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Random evaluations with gaps
    for (int t = 0; t < 6; t++) begin
      b  = 8'($urandom);
      xs = $urandom;
      ws = $urandom;
      drive_eval(b, xs, ws, model(b, xs, ws), t % 3, t % 2);
    end

    if (sb.size() != 0) check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
